mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Three-requester memory port arbiter: data, fetch and loader share one
// fixed-latency memory port, one transaction at a time.
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int LAT    = 2,
  parameter int STARVE = 4
) (
  input  logic          clk1,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          if_done,
  output logic          d_done,
  output logic          ld_done,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_D, OWN_LD} owner_t;

  localparam logic [3:0] LAT_LAST   = 4'(LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE);

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  logic            we_q, we_d;
  logic [3:0]      wait_q, wait_d;
  logic [3:0]      starve_q, starve_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            if_done_q, if_done_d;
  logic            d_done_q, d_done_d;
  logic            ld_done_q, ld_done_d;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      wait_q      <= 4'd0;
      starve_q    <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      ld_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      ld_done_q   <= ld_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    ld_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // Loader wins when starved or when it is the only requester.
        if (ld_req && (starve_q == STARVE_MAX || !(d_req || if_req))) begin
          owner_d     = OWN_LD;
          we_d        = 1'b1;
          mem_addr_d  = ld_addr;
          mem_wdata_d = ld_wdata;
          starve_d    = 4'd0;
          state_d     = ISSUE;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
        end else if (d_req || if_req) begin
          if (d_req) begin
            owner_d     = OWN_D;
            we_d        = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_we_d    = d_we;
          end else begin
            owner_d     = OWN_IF;
            we_d        = 1'b0;
            mem_addr_d  = if_addr;
            mem_we_d    = 1'b0;
          end
          if (ld_req) starve_d = starve_q + 4'd1;
          state_d  = ISSUE;
          mem_en_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wait_d  = 4'd0;
      end
      WAIT: begin
        if (wait_q == LAT_LAST) begin
          state_d = DONE;
          if (!we_q) rdata_d = mem_rdata;
          case (owner_q)
            OWN_IF:  if_done_d = 1'b1;
            OWN_D:   d_done_d  = 1'b1;
            OWN_LD:  ld_done_d = 1'b1;
            default: ;
          endcase
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign ld_done   = ld_done_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);
  assign stall     = (if_req & ~if_done_q) | (d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a LAT=2 instance for fetch/data/loader/reset scenarios and
// a LAT=1 instance for back-to-back fetch spacing.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, ld_req;
  logic [31:0] if_addr, d_addr, d_wdata, ld_addr, ld_wdata;
  logic        if_done, d_done, ld_done, mem_en, mem_we, stall, busy;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if_req1;
  logic [31:0] if_addr1;
  logic        if_done1, d_done1, ld_done1, mem_en1, mem_we1, stall1, busy1;
  logic [31:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(2), .STARVE(4)) dut (
    .clk1(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .if_done(if_done), .d_done(d_done), .ld_done(ld_done), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall(stall), .busy(busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(1), .STARVE(4)) dut1 (
    .clk1(clk), .reset(rst),
    .if_req(if_req1), .if_addr(if_addr1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
    .ld_req(1'b0), .ld_addr(32'd0), .ld_wdata(32'd0),
    .if_done(if_done1), .d_done(d_done1), .ld_done(ld_done1), .rdata(rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .stall(stall1), .busy(busy1)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'd5:   return 32'h0c631800;
      32'd120: return 32'd85;
      32'd3:   return 32'h33;
      32'd7:   return 32'h77;
      default: return a ^ 32'h5a5a;
    endcase
  endfunction

  // Memory models: read data appears LAT cycles after the mem_en cycle.
  logic [31:0] s1 = '0, s2 = '0, rd1 = '0, wr_addr = '0, wr_data = '0;
  int en_cnt = 0;
  always @(posedge clk) begin
    if (mem_en && !mem_we) s1 <= memf(mem_addr);
    s2 <= s1;
    if (mem_en) en_cnt <= en_cnt + 1;
    if (mem_en && mem_we) begin
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
    if (mem_en1) rd1 <= 32'h1000 + mem_addr1;
  end
  assign mem_rdata  = s2;
  assign mem_rdata1 = rd1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // sel: 0=if, 1=d, 2=ld. Returns the number of negedges until that done.
  task automatic wait_done(input int sel, input int maxc, output int n);
    bit found = 1'b0;
    n = 0;
    for (int i = 1; i <= maxc && !found; i++) begin
      @(negedge clk);
      n = i;
      found = (sel == 0) ? if_done : (sel == 1) ? d_done : ld_done;
    end
    if (!found) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_any(input int maxc, output int code);
    bit found = 1'b0;
    code = -1;
    for (int i = 1; i <= maxc && !found; i++) begin
      @(negedge clk);
      found = if_done | d_done | ld_done;
      if (found) code = if_done ? 0 : d_done ? 1 : 2;
    end
    if (!found) check("any_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, code, e0, k;
    rst = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; ld_req = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; ld_addr = 0; ld_wdata = 0;
    if_req1 = 0; if_addr1 = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_outs", {if_done, d_done, ld_done, mem_we}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch
    if_addr = 5; if_req = 1;
    @(negedge clk);
    check("fetch_issue", {mem_en, mem_we, busy, stall}, 4'b1011);
    check("fetch_addr", mem_addr, 5);
    wait_done(0, 10, n);
    check("fetch_lat", n + 1, 4);
    check("fetch_rdata", rdata, 32'h0c631800);
    check("fetch_stall_done", stall, 0);
    if_req = 0;
    @(negedge clk);
    check("fetch_idle", {busy, if_done}, 0);

    // Contention: d before if
    d_req = 1; d_we = 0; d_addr = 120; if_req = 1; if_addr = 3;
    wait_done(1, 10, n);
    check("cont_d_lat", n, 4);
    check("cont_d_rdata", rdata, 85);
    check("cont_if_not_yet", if_done, 0);
    d_req = 0;
    wait_done(0, 10, n);
    check("cont_if_gap", n, 5);
    check("cont_if_rdata", rdata, 32'h33);
    if_req = 0;
    @(negedge clk);

    // Store
    e0 = en_cnt;
    d_req = 1; d_we = 1; d_addr = 121; d_wdata = 130;
    @(negedge clk);
    check("st_issue", {mem_en, mem_we}, 2'b11);
    check("st_addr", mem_addr, 121);
    check("st_wdata", mem_wdata, 130);
    wait_done(1, 10, n);
    check("st_lat", n + 1, 4);
    check("st_en_cycles", en_cnt - e0, 1);
    check("st_rdata_kept", rdata, 32'h33);
    check("st_written", {wr_addr, wr_data}, {32'd121, 32'd130});
    d_req = 0; d_we = 0;
    @(negedge clk);

    // Starvation: loader wins the fifth arbitration
    ld_req = 1; ld_addr = 200; ld_wdata = 32'habcd; if_req = 1; if_addr = 7;
    for (int i = 1; i <= 5; i++) begin
      wait_any(10, code);
      check($sformatf("starve_win%0d", i), code, (i < 5) ? 0 : 2);
    end
    ld_req = 0; if_req = 0;
    check("starve_cnt_clear", dut.starve_q, 0);
    check("starve_rdata_kept", rdata, 32'h77);
    check("ld_written", {wr_addr, wr_data}, {32'd200, 32'habcd});
    @(negedge clk);

    // Reset during WAIT
    if_addr = 5; if_req = 1;
    @(negedge clk);
    @(negedge clk);
    check("rw_in_wait", busy, 1);
    rst = 1'b1;
    #1;
    check("rw_busy", busy, 0);
    check("rw_outs", {if_done, d_done, ld_done, mem_en, mem_we}, 0);
    check("rw_rdata", rdata, 0);
    check("rw_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    check("rw_no_done", if_done, 0);
    rst = 1'b0;
    wait_done(0, 10, n);
    check("rw_after_lat", n, 4);
    check("rw_after_rdata", rdata, 32'h0c631800);
    if_req = 0;
    @(negedge clk);

    // Back-to-back fetches, LAT=1
    if_addr1 = 0; if_req1 = 1; k = 0;
    for (int c = 1; c <= 40 && k < 8; c++) begin
      bit exp_done;
      @(negedge clk);
      exp_done = (c >= 3) && ((c - 3) % 4 == 0);
      check($sformatf("b2b_done_c%0d", c), if_done1, exp_done);
      check($sformatf("b2b_stall_c%0d", c), stall1, !exp_done);
      if (if_done1) begin
        check($sformatf("b2b_rdata%0d", k), rdata1, 32'h1000 + k);
        k++;
        if (k == 8) if_req1 = 0;
        else if_addr1 = k;
      end
    end
    check("b2b_count", k, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
